// File: rtl/gpr_sched_pkg.sv
// Shared types and helpers for the GPR write-port scheduler.
package gpr_sched_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sched_state_t;

  // Modulo-n increment of a round-robin index.
  function automatic int unsigned ptr_wrap(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: first eligible requester at or after ptr, modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [NUM_REQ-1:0] elig;
  int                 j;

  assign elig = valid & ~excl;

  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && elig[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gpr_write_scheduler.sv
// Shares the two register-file write ports between NUM_REQ writeback requesters and runs the clear sequence.
module gpr_write_scheduler
  import gpr_sched_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 3,
  parameter int NUM_REQ   = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][AW-1:0]        req_addr,
  input  logic [NUM_REQ-1:0][BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              clear_req,
  output logic                              clear_busy,
  output logic                              we_a,
  output logic                              we_b,
  output logic [AW-1:0]                     wr_addr_a,
  output logic [AW-1:0]                     wr_addr_b,
  output logic [BUS_WIDTH-1:0]              wr_data_a,
  output logic [BUS_WIDTH-1:0]              wr_data_b,
  output logic                              err_addr
);

  localparam int          IW      = $clog2(NUM_REQ);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  sched_state_t        state;
  logic [AW:0]         clr_addr;
  logic [AW:0]         clr_addr_b;
  logic [AW+1:0]       clr_addr_end;
  logic [IW-1:0]       rr_ptr;

  logic [NUM_REQ-1:0]  grant_a, grant_b, same_addr;
  logic [IW-1:0]       idx_a, idx_b;
  logic                found_a, found_b;
  logic [AW-1:0]       addr_a, addr_b;
  logic [BUS_WIDTH-1:0] data_a, data_b;
  logic                oob_a, oob_b;
  logic                run_ok;

  assign clear_busy   = (state == CLEAR);
  assign run_ok       = (state == RUN) && !clear_req;
  assign clr_addr_b   = clr_addr + 1'b1;
  assign clr_addr_end = {1'b0, clr_addr} + (AW+2)'(2);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_a (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .excl  ('0),
    .grant (grant_a),
    .idx   (idx_a),
    .found (found_a)
  );

  assign addr_a = req_addr[idx_a];
  assign data_a = req_data[idx_a];

  // Port B skips A's winner and anything aimed at A's register, so the two ports never collide.
  always_comb begin
    same_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      same_addr[i] = (req_addr[i] == addr_a);
    end
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_b (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .excl  (grant_a | same_addr),
    .grant (grant_b),
    .idx   (idx_b),
    .found (found_b)
  );

  assign addr_b    = req_addr[idx_b];
  assign data_b    = req_data[idx_b];
  assign oob_a     = ({1'b0, addr_a} >= DEPTH_W);
  assign oob_b     = ({1'b0, addr_b} >= DEPTH_W);
  assign req_ready = run_ok ? (grant_a | grant_b) : '0;

  // NOTE: all state here is sequential, so it is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      rr_ptr    <= '0;
      we_a      <= 1'b0;
      we_b      <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
      err_addr  <= 1'b0;
    end else begin
      we_a      <= 1'b0;
      we_b      <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
      err_addr  <= 1'b0;
      case (state)
        CLEAR: begin
          we_a      <= 1'b1;
          wr_addr_a <= clr_addr[AW-1:0];
          we_b      <= (clr_addr_b < DEPTH_W);
          wr_addr_b <= clr_addr_b[AW-1:0];
          clr_addr  <= clr_addr + (AW+1)'(2);
          if (clr_addr_end >= {1'b0, DEPTH_W}) state <= RUN;
        end
        RUN: begin
          if (clear_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end else begin
            if (found_a) begin
              we_a      <= !oob_a;
              wr_addr_a <= addr_a;
              wr_data_a <= data_a;
            end
            if (found_b) begin
              we_b      <= !oob_b;
              wr_addr_b <= addr_b;
              wr_data_b <= data_b;
            end
            err_addr <= (found_a && oob_a) || (found_b && oob_b);
            if (found_b)      rr_ptr <= IW'(ptr_wrap(32'(idx_b), NUM_REQ));
            else if (found_a) rr_ptr <= IW'(ptr_wrap(32'(idx_a), NUM_REQ));
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_write_scheduler.sv
// Directed plus randomized bench for gpr_write_scheduler against a cycle-level scoreboard model.
module tb_gpr_write_scheduler;

  localparam int BUS_WIDTH = 8;
  localparam int DEPTH     = 3;
  localparam int NUM_REQ   = 3;
  localparam int AW        = $clog2(DEPTH);

  logic                              clk;
  logic                              rst_n;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][AW-1:0]        req_addr;
  logic [NUM_REQ-1:0][BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              clear_req;
  logic                              clear_busy;
  logic                              we_a, we_b;
  logic [AW-1:0]                     wr_addr_a, wr_addr_b;
  logic [BUS_WIDTH-1:0]              wr_data_a, wr_data_b;
  logic                              err_addr;

  gpr_write_scheduler #(
    .BUS_WIDTH(BUS_WIDTH),
    .DEPTH    (DEPTH),
    .NUM_REQ  (NUM_REQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .we_a      (we_a),
    .we_b      (we_b),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester side: pending requests held until granted.
  bit v[NUM_REQ];
  int a[NUM_REQ];
  int d[NUM_REQ];

  // Scheduler model: mode, clear position, round-robin start.
  bit m_clear = 1'b1;
  int m_clr   = 0;
  int m_ptr   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int i, input int addr, input int data);
    v[i] = 1'b1;
    a[i] = addr;
    d[i] = data;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b0;
  endtask

  // One clock: drive, check grants mid-cycle, predict and check registered ports after the edge.
  task automatic cycle();
    int ga, gb, i;
    logic [31:0] exp_ready;
    bit ewa, ewb, eerr;
    int eaa, eab, eda, edb;

    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid[k] = v[k];
      req_addr[k]  = AW'(a[k]);
      req_data[k]  = BUS_WIDTH'(d[k]);
    end

    @(negedge clk);
    ga = -1;
    gb = -1;
    if (rst_n && !m_clear && !clear_req) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        i = (m_ptr + k) % NUM_REQ;
        if (v[i]) begin
          if (ga < 0) ga = i;
          else if (gb < 0 && a[i] != a[ga]) gb = i;
        end
      end
    end
    exp_ready = '0;
    if (ga >= 0) exp_ready[ga] = 1'b1;
    if (gb >= 0) exp_ready[gb] = 1'b1;
    if (rst_n) begin
      check("req_ready", 32'(req_ready), exp_ready);
      check("clear_busy", 32'(clear_busy), 32'(m_clear));
    end

    ewa = 0; ewb = 0; eerr = 0;
    eaa = 0; eab = 0; eda = 0; edb = 0;
    if (!rst_n) begin
      m_clear = 1'b1;
      m_clr   = 0;
      m_ptr   = 0;
    end else if (m_clear) begin
      ewa = 1'b1;
      eaa = m_clr;
      ewb = (m_clr + 1 < DEPTH);
      eab = m_clr + 1;
      if (m_clr + 2 >= DEPTH) m_clear = 1'b0;
      m_clr += 2;
    end else if (clear_req) begin
      m_clear = 1'b1;
      m_clr   = 0;
    end else begin
      if (ga >= 0) begin
        ewa  = (a[ga] < DEPTH);
        eaa  = a[ga];
        eda  = d[ga];
        eerr = (a[ga] >= DEPTH);
      end
      if (gb >= 0) begin
        ewb  = (a[gb] < DEPTH);
        eab  = a[gb];
        edb  = d[gb];
        eerr = eerr || (a[gb] >= DEPTH);
      end
      if (gb >= 0)      m_ptr = (gb + 1) % NUM_REQ;
      else if (ga >= 0) m_ptr = (ga + 1) % NUM_REQ;
      if (ga >= 0) v[ga] = 1'b0;
      if (gb >= 0) v[gb] = 1'b0;
    end

    @(posedge clk);
    #1;
    check("we_a", 32'(we_a), 32'(ewa));
    check("we_b", 32'(we_b), 32'(ewb));
    check("err_addr", 32'(err_addr), 32'(eerr));
    if (ewa) begin
      check("wr_addr_a", 32'(wr_addr_a), eaa);
      check("wr_data_a", 32'(wr_data_a), eda);
    end
    if (ewb) begin
      check("wr_addr_b", 32'(wr_addr_b), eab);
      check("wr_data_b", 32'(wr_data_b), edb);
    end
    if (!rst_n) begin
      check("rst_addr", 32'({wr_addr_a, wr_addr_b}), 32'(0));
      check("rst_data", 32'({wr_data_a, wr_data_b}), 32'(0));
    end
    if (we_a && we_b) check("port_addr_differ", 32'(wr_addr_a != wr_addr_b), 32'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    clear_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b0;
      a[i] = 0;
      d[i] = 0;
    end
    @(posedge clk);
    #1;

    // Reset, then the two-cycle clear of registers 0..2.
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();

    // Three distinct addresses from rr_ptr=0: grants 0,1 then 2,0.
    post(0, 0, 8'h11);
    post(1, 1, 8'h22);
    post(2, 2, 8'h33);
    cycle();
    post(0, 0, 8'h44);
    cycle();
    cycle();

    // Bring rr_ptr back to 0, then a same-address pair.
    post(2, 1, 8'h55);
    cycle();
    post(0, 1, 8'h66);
    post(1, 1, 8'h77);
    cycle();
    cycle();
    cycle();

    // Out-of-range address consumes a grant but never writes.
    post(2, 3, 8'h88);
    cycle();
    cycle();

    // Clear request with pending traffic.
    post(0, 2, 8'h99);
    post(1, 0, 8'haa);
    post(2, 1, 8'hbb);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    cycle();
    cycle();
    cycle();
    cycle();
    cycle();

    // Reset during the second clear cycle restarts the clear.
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    cycle();

    // Randomized traffic, including out-of-range addresses and occasional clears.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 9) < 6) begin
          if ($urandom_range(0, 9) == 0) post(i, 3, int'($urandom_range(0, 255)));
          else post(i, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
        end
      end
      clear_req = ($urandom_range(0, 39) == 0);
      cycle();
      clear_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpr_write_scheduler.md
# gpr_write_scheduler

Sequences and shares the two write ports of the dual-port general-purpose register file between NUM_REQ writeback requesters (ALU, load unit, debug), using round-robin arbitration with same-address conflict avoidance. After reset, or on request, it also runs a clear sequence that zeroes every register through both ports. It sits between the writeback stage and the register file: write-port signals drive the register file directly; read ports are untouched.

## Interface
- BUS_WIDTH, 8, register data width
- DEPTH, 3, number of registers; AW = $clog2(DEPTH)
- NUM_REQ, 3, number of write requesters (2..8)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  [NUM_REQ]  requester i has a write pending
- req_addr  input  [NUM_REQ][AW]  target register per requester
- req_data  input  [NUM_REQ][BUS_WIDTH]  write data per requester
- req_ready  output  [NUM_REQ]  combinational grant; handshake = valid & ready
- clear_req  input  1  one-cycle pulse: re-run the clear sequence
- clear_busy  output  1  high while in CLEAR
- we_a, we_b  output  1  register-file write enables
- wr_addr_a, wr_addr_b  output  AW  register-file write addresses
- wr_data_a, wr_data_b  output  BUS_WIDTH  register-file write data
- err_addr  output  1  one-cycle pulse: an accepted request had addr >= DEPTH

## Operation
- States: CLEAR, RUN. Reset: state=CLEAR, clr_addr=0, rr_ptr=0; all registered outputs (we_*, wr_addr_*, wr_data_*, err_addr) = 0.
- CLEAR: req_ready all 0. Each cycle schedule port A = clr_addr and port B = clr_addr+1 (B enabled only if clr_addr+1 < DEPTH), data 0; clr_addr += 2. When clr_addr+2 >= DEPTH, go to RUN at that edge. clr_addr is AW+1 bits wide so it cannot wrap.
- RUN: scan requesters from rr_ptr upward, modulo NUM_REQ.
  - First valid requester is granted port A.
  - Next valid requester whose addr differs from port A's addr is granted port B.
  - Same-address requesters are not granted this cycle and keep waiting.
  - At most two grants per cycle.
- rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. rr_ptr is unchanged when no requester is granted.
- Out-of-range addr (>= DEPTH): the request is granted normally and consumes its port slot, but the corresponding we stays 0. err_addr pulses on the next cycle.
- clear_req in RUN: no grants in that cycle; enter CLEAR at the edge with clr_addr=0. clear_req during CLEAR is ignored.
- rst_n low in any state: reset values at that edge. A clear in progress restarts from 0.
- Two enabled ports never carry the same address. The register file's same-address dual-write hazard is therefore impossible.

## Timing
- Grant (req_ready) is combinational in cycle N. Port signals are registered and valid in cycle N+1. The register file commits at the end of N+1.
- A register-file read in cycle N+2 returns the data granted in cycle N.
- CLEAR lasts ceil(DEPTH/2) cycles. For DEPTH=3: 2 cycles; first RUN cycle is the 3rd cycle after reset release.
- clear_busy = (state==CLEAR). It is combinational from state and drops in the first RUN cycle.
- we_* are deasserted one cycle after the last grant, with no hold.
- Requesters must hold valid/addr/data stable until granted. The scheduler does not buffer requests.

## Structure
- Package gpr_sched_pkg: state enum sched_state_t {CLEAR, RUN}, and the function ptr_wrap() for modulo-NUM_REQ increment.
- Sub-module rr_pick: combinational rotate-priority search. It takes the valid vector, rr_ptr and an exclude-address mask, and returns a one-hot grant and an index. It is instanced twice: once for port A, and once for port B with port A's winner masked out.
- Top level: FSM, clear counter, rr_ptr register, and output registers.

## Test plan
- Reset, DEPTH=3: cycle 1 shows we_a=1 addr0 and we_b=1 addr1, data 0; cycle 2 shows we_a=1 addr2 and we_b=0; clear_busy high for 2 cycles; then RUN.
- All three requesters valid with distinct addrs 0/1/2, rr_ptr=0: grants to 0 and 1, then rr_ptr=2; next cycle grants to 2 and 0.
- Requesters 0 and 1 both targeting addr 1: only 0 granted; 1 granted the following cycle; never we_a & we_b with equal addresses.
- Requester 2 writes addr 3 (DEPTH=3): req_ready[2]=1, we stays 0, err_addr pulses once on the next cycle.
- clear_req while requests are pending: no grants in that cycle, 2 CLEAR cycles follow, then the pending requests are granted in round-robin order.
- rst_n low in the second CLEAR cycle: outputs return to 0; the clear restarts at addr 0 after reset release.
